hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Detects hazards the forwarding path cannot resolve (load-use, multi-cycle multiply/divide occupancy) and drives PC/IF-ID write enables and IF-ID/ID-EX flushes accordingly. Also owns branch-taken flushing and the terminal HALT state. Sits beside the forwarding unit in the ID/EX control path.

---
 rtl/hazard_controller_if.sv | 48 ++++
 rtl/hazard_controller.sv | 117 +++++++++++
 tb/tb_hazard_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller bus: hazard sources from ID/EX/WB in, pipeline enables and flushes out.
// The i_step single-step input exists only when HAZARD_STEP_EN is defined.
interface hazard_controller_if #(
    parameter int unsigned REG_ADDRS_BITS = 5
);
    logic [REG_ADDRS_BITS-1:0] i_id_rs;
    logic [REG_ADDRS_BITS-1:0] i_id_rt;
    logic                      i_id_uses_rt;
    logic                      i_id_md_access;
    logic                      i_id_ex_MemRead;
    logic [REG_ADDRS_BITS-1:0] i_id_ex_rt;
    logic                      i_ex_md_start;
    logic                      i_ex_branch_taken;
    logic                      i_wb_halt;
`ifdef HAZARD_STEP_EN
    logic                      i_step;
`endif
    logic                      o_pc_write;
    logic                      o_if_id_write;
    logic                      o_if_id_flush;
    logic                      o_id_ex_flush;
    logic                      o_md_busy;
    logic                      o_halted;

    // Pipeline side: supplies hazard sources, consumes enables.
    modport master (
`ifdef HAZARD_STEP_EN
        output i_step,
`endif
        output i_id_rs, i_id_rt, i_id_uses_rt, i_id_md_access,
        output i_id_ex_MemRead, i_id_ex_rt, i_ex_md_start,
        output i_ex_branch_taken, i_wb_halt,
        input  o_pc_write, o_if_id_write, o_if_id_flush,
        input  o_id_ex_flush, o_md_busy, o_halted
    );

    // Controller side.
    modport slave (
`ifdef HAZARD_STEP_EN
        input  i_step,
`endif
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_md_access,
        input  i_id_ex_MemRead, i_id_ex_rt, i_ex_md_start,
        input  i_ex_branch_taken, i_wb_halt,
        output o_pc_write, o_if_id_write, o_if_id_flush,
        output o_id_ex_flush, o_md_busy, o_halted
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use / HI-LO occupancy stalls, branch flushes, sticky HALT.
// Optional HAZARD_STEP_EN adds single-step gating via i_step.
module hazard_controller #(
    parameter int unsigned REG_ADDRS_BITS = 5,
    parameter int unsigned MD_LATENCY     = 32,
    parameter int unsigned CNT_BITS       = 6
) (
    input logic                i_clk,
    input logic                i_rst_n,
    hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    // Issue cycle plus the terminal zero count are both part of the occupancy.
    localparam logic [CNT_BITS-1:0] MD_CNT_INIT = CNT_BITS'(MD_LATENCY - 2);

    state_t              state;
    state_t              state_nx;
    logic [CNT_BITS-1:0] md_cnt;
    logic [CNT_BITS-1:0] md_cnt_nx;
    logic                step_ok;
    logic                load_use;
    logic                md_stall;
    logic                pc_write_c;
    logic                if_id_write_c;
    logic                if_id_flush_c;
    logic                id_ex_flush_c;

`ifdef HAZARD_STEP_EN
    assign step_ok = bus.i_step;
`else
    assign step_ok = 1'b1;
`endif

    assign load_use = bus.i_id_ex_MemRead
                   && (bus.i_id_ex_rt != REG_ADDRS_BITS'(0))
                   && ((bus.i_id_ex_rt == bus.i_id_rs)
                       || (bus.i_id_uses_rt && (bus.i_id_ex_rt == bus.i_id_rt)));
    assign md_stall = (state == ST_MD_BUSY) && bus.i_id_md_access;

    // State and occupancy counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    // Next state; HALT request overrides everything and is sticky.
    always_comb begin
        state_nx  = state;
        md_cnt_nx = md_cnt;
        case (state)
            ST_RUN: begin
                if (step_ok && bus.i_ex_md_start) begin
                    state_nx  = ST_MD_BUSY;
                    md_cnt_nx = MD_CNT_INIT;
                end
            end
            ST_MD_BUSY: begin
                if (step_ok) begin
                    if (md_cnt == '0) begin
                        state_nx = ST_RUN;
                    end else begin
                        md_cnt_nx = md_cnt - CNT_BITS'(1);
                    end
                end
            end
            ST_HALT: begin
                state_nx = ST_HALT;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
        if (bus.i_wb_halt) begin
            state_nx = ST_HALT;
        end
    end

    // Same-cycle enables/flushes; a taken branch beats a stall.
    always_comb begin
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        if (state == ST_HALT) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
        end else if (!step_ok) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
        end else if (bus.i_ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (load_use || md_stall) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
        end
    end

    assign bus.o_pc_write    = pc_write_c;
    assign bus.o_if_id_write = if_id_write_c;
    assign bus.o_if_id_flush = if_id_flush_c;
    assign bus.o_id_ex_flush = id_ex_flush_c;
    assign bus.o_md_busy     = (state == ST_MD_BUSY);
    assign bus.o_halted      = (state == ST_HALT);

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table in RUN plus MD/HALT/reset sequences.
// Expected word layout: {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, halted}.
module tb_hazard_controller;
    localparam int unsigned RW  = 5;
    localparam int unsigned LAT = 4;

    localparam logic [5:0] E_RUN   = 6'b110000;
    localparam logic [5:0] E_STALL = 6'b000100;
    localparam logic [5:0] E_BR    = 6'b111100;
    localparam logic [5:0] E_MDSTL = 6'b000110;
    localparam logic [5:0] E_MDRUN = 6'b110010;
    localparam logic [5:0] E_HALT  = 6'b000001;

    typedef struct {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          uses_rt;
        logic          md_access;
        logic          mem_read;
        logic [RW-1:0] ex_rt;
        logic          branch;
        logic [5:0]    exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [5:0] exp_q[$];
    string      name_q[$];
    vec_t       vecs[12];

    always #5 clk = ~clk;

    hazard_controller_if #(.REG_ADDRS_BITS(RW)) hif();

    hazard_controller #(
        .REG_ADDRS_BITS(RW),
        .MD_LATENCY(LAT),
        .CNT_BITS(6)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(hif)
    );

    function automatic logic [5:0] outs();
        return {hif.o_pc_write, hif.o_if_id_write, hif.o_if_id_flush,
                hif.o_id_ex_flush, hif.o_md_busy, hif.o_halted};
    endfunction

    task automatic clear_inputs();
        hif.i_id_rs           = '0;
        hif.i_id_rt           = '0;
        hif.i_id_uses_rt      = 1'b0;
        hif.i_id_md_access    = 1'b0;
        hif.i_id_ex_MemRead   = 1'b0;
        hif.i_id_ex_rt        = '0;
        hif.i_ex_md_start     = 1'b0;
        hif.i_ex_branch_taken = 1'b0;
        hif.i_wb_halt         = 1'b0;
`ifdef HAZARD_STEP_EN
        hif.i_step            = 1'b1;
`endif
    endtask

    // Scoreboard: expectation queued with the stimulus, popped when outputs are sampled.
    task automatic expect_out(input string name, input logic [5:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic check_out();
        logic [5:0] e;
        string      n;
        logic [5:0] a;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty got=none want=entry");
            bad++;
            total++;
            return;
        end
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = outs();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%b want=%b", n, a, e);
        end
    endtask

    // Expect now, sample at the falling edge, then advance past the next rising edge.
    task automatic cycle_check(input string name, input logic [5:0] e);
        expect_out(name, e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_RUN};
        vecs[1]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, E_STALL};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, E_RUN};
        vecs[3]  = '{5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, E_RUN};
        vecs[4]  = '{5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, E_STALL};
        vecs[5]  = '{5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, E_RUN};
        vecs[6]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, E_BR};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_BR};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN};
        vecs[9]  = '{5'd7, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, E_RUN};
        vecs[10] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, E_RUN};
        vecs[11] = '{5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_STALL};

        clear_inputs();
        #2;
        expect_out("reset_state", E_RUN);
        #1;
        check_out();
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Combinational decode in RUN.
        for (int i = 0; i < 12; i++) begin
            hif.i_id_rs           = vecs[i].rs;
            hif.i_id_rt           = vecs[i].rt;
            hif.i_id_uses_rt      = vecs[i].uses_rt;
            hif.i_id_md_access    = vecs[i].md_access;
            hif.i_id_ex_MemRead   = vecs[i].mem_read;
            hif.i_id_ex_rt        = vecs[i].ex_rt;
            hif.i_ex_branch_taken = vecs[i].branch;
            cycle_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load-use followed by its bubble: exactly one stall cycle.
        clear_inputs();
        hif.i_id_ex_MemRead = 1'b1;
        hif.i_id_ex_rt      = 5'd8;
        hif.i_id_rs         = 5'd8;
        cycle_check("lu_stall", E_STALL);
        hif.i_id_ex_MemRead = 1'b0;
        hif.i_id_ex_rt      = 5'd0;
        cycle_check("lu_release", E_RUN);

        // Mult/div occupancy with mfhi waiting in ID; a stray start while busy is ignored.
        clear_inputs();
        hif.i_ex_md_start = 1'b1;
        cycle_check("md_issue", E_RUN);
        hif.i_ex_md_start  = 1'b0;
        hif.i_id_md_access = 1'b1;
        cycle_check("md_busy1", E_MDSTL);
        hif.i_ex_md_start = 1'b1;
        cycle_check("md_busy2", E_MDSTL);
        hif.i_ex_md_start = 1'b0;
        cycle_check("md_busy3", E_MDSTL);
        cycle_check("md_done", E_RUN);
        cycle_check("md_idle", E_RUN);

`ifdef HAZARD_STEP_EN
        // Held pipeline freezes the counter; each step pulse consumes one count.
        clear_inputs();
        hif.i_ex_md_start = 1'b1;
        cycle_check("st_issue", E_RUN);
        hif.i_ex_md_start = 1'b0;
        hif.i_step        = 1'b0;
        for (int k = 0; k < 5; k++) cycle_check($sformatf("st_hold%0d", k), 6'b000010);
        hif.i_step = 1'b1;
        cycle_check("st_pulse", E_MDRUN);
        cycle_check("st_cnt1", E_MDRUN);
        cycle_check("st_cnt0", E_MDRUN);
        cycle_check("st_done", E_RUN);
        hif.i_step = 1'b0;
        cycle_check("st_run_hold", 6'b000000);
        hif.i_step = 1'b1;
`endif

        // Async reset in the middle of MD_BUSY.
        clear_inputs();
        hif.i_ex_md_start = 1'b1;
        cycle_check("rst_md_issue", E_RUN);
        hif.i_ex_md_start = 1'b0;
        expect_out("rst_md_busy", E_MDRUN);
        #1;
        check_out();
        rst_n = 1'b0;
        #1;
        expect_out("rst_md_cleared", E_RUN);
        check_out();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hif.i_id_md_access = 1'b1;
        cycle_check("rst_md_no_stall", E_RUN);

        // HALT with a simultaneous taken branch and load-use.
        clear_inputs();
        hif.i_wb_halt         = 1'b1;
        hif.i_ex_branch_taken = 1'b1;
        hif.i_id_ex_MemRead   = 1'b1;
        hif.i_id_ex_rt        = 5'd8;
        hif.i_id_rs           = 5'd8;
        cycle_check("halt_branch_same", E_BR);
        hif.i_wb_halt = 1'b0;
        for (int k = 0; k < 3; k++) cycle_check($sformatf("halted%0d", k), E_HALT);
        hif.i_ex_md_start = 1'b1;
        cycle_check("halted_md_start", E_HALT);

        // Async reset out of HALT.
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("rst_from_halt", E_RUN);
        check_out();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle_check("run_after_halt", E_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
